// File: rtl/fifo_wptr_afull.sv
// ---------------------------------------------------------------------------
// fifo_wptr_afull
// Write-side pointer and status block of an asynchronous FIFO. It keeps the
// binary write pointer, the Gray-coded pointer handed to the read domain, and
// derives full, almost-full, fill level and a sticky overflow flag. The read
// pointer arrives already synchronised into wclk.
//
// Parameters
//   ADDRSIZE      address width; FIFO depth is 2**ADDRSIZE (ADDRSIZE >= 2)
//   AFULL_THRESH  fill level at or above which wafull is set (1..2**ADDRSIZE)
//
// Ports
//   wclk       in   1           write clock, rising edge
//   wrst_n     in   1           asynchronous active-low reset
//   winc       in   1           write request
//   wq2_rptr   in   ADDRSIZE+1  synchronised Gray read pointer
//   wovf_clr   in   1           clear for the sticky overflow flag
//   wptr       out  ADDRSIZE+1  registered Gray write pointer
//   waddr      out  ADDRSIZE    RAM write address
//   wen        out  1           RAM write enable (winc & ~wfull)
//   wfull      out  1           registered full flag
//   wafull     out  1           registered almost-full flag
//   wlevel     out  ADDRSIZE+1  registered fill level 0..2**ADDRSIZE
//   woverflow  out  1           sticky: write attempted while full
// ---------------------------------------------------------------------------
module fifo_wptr_afull #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = (2 ** ADDRSIZE) - 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wen,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE + 1)'(AFULL_THRESH);

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b           = '0;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDRSIZE:0] r_wbin;
    logic [ADDRSIZE:0] r_wptr;
    logic              r_wfull;
    logic              r_wafull;
    logic [ADDRSIZE:0] r_wlevel;
    logic              r_wovf;

    logic              w_wen;
    logic [ADDRSIZE:0] w_wbnext;
    logic [ADDRSIZE:0] w_wgnext;
    logic [ADDRSIZE:0] w_rbin;
    logic [ADDRSIZE:0] w_diff;
    logic [ADDRSIZE:0] w_full_ptr;
    logic              w_full_next;
    logic              w_afull_next;
    logic              w_ovf_next;

    // A write is accepted only when the FIFO is not full.
    assign w_wen    = winc & ~r_wfull;
    assign w_wbnext = r_wbin + {{ADDRSIZE{1'b0}}, w_wen};
    assign w_wgnext = (w_wbnext >> 1) ^ w_wbnext;
    assign w_rbin   = gray2bin(wq2_rptr);

    // Modulo 2**(ADDRSIZE+1) distance; the extra pointer bit makes a full
    // FIFO read as 2**ADDRSIZE instead of aliasing to 0.
    assign w_diff   = w_wbnext - w_rbin;

    // Full when the next write pointer is one lap ahead of the read pointer:
    // in Gray code that means the top two bits differ and the rest match.
    assign w_full_ptr = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

    // Next-state flags for full, almost-full and the sticky overflow.
    always_comb begin
        w_full_next  = 1'b0;
        w_afull_next = 1'b0;
        w_ovf_next   = r_wovf;
        if (w_wgnext == w_full_ptr) begin
            w_full_next = 1'b1;
        end else begin
            w_full_next = 1'b0;
        end
        if (w_diff >= AFULL_LVL) begin
            w_afull_next = 1'b1;
        end else begin
            w_afull_next = 1'b0;
        end
        // Setting wins over clearing when both happen in the same cycle.
        if (winc & r_wfull) begin
            w_ovf_next = 1'b1;
        end else if (wovf_clr) begin
            w_ovf_next = 1'b0;
        end else begin
            w_ovf_next = r_wovf;
        end
    end

    // Pointer, level and flag registers; all cleared asynchronously.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin   <= '0;
            r_wptr   <= '0;
            r_wfull  <= 1'b0;
            r_wafull <= 1'b0;
            r_wlevel <= '0;
            r_wovf   <= 1'b0;
        end else begin
            r_wbin   <= w_wbnext;
            r_wptr   <= w_wgnext;
            r_wfull  <= w_full_next;
            r_wafull <= w_afull_next;
            r_wlevel <= w_diff;
            r_wovf   <= w_ovf_next;
        end
    end

    assign wptr      = r_wptr;
    assign waddr     = r_wbin[ADDRSIZE-1:0];
    assign wen       = w_wen;
    assign wfull     = r_wfull;
    assign wafull    = r_wafull;
    assign wlevel    = r_wlevel;
    assign woverflow = r_wovf;

endmodule

// File: tb/tb_fifo_wptr_afull.sv
// Testbench for fifo_wptr_afull with ADDRSIZE=3 (depth 8) and AFULL_THRESH=6.
// Stimulus steps push hand-computed expected outputs into a queue; a monitor
// samples the DUT 2 time units after each rising edge and compares.
module tb_fifo_wptr_afull;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [3:0] wq2_rptr;
    logic       wovf_clr;
    logic [3:0] wptr;
    logic [2:0] waddr;
    logic       wen;
    logic       wfull;
    logic       wafull;
    logic [3:0] wlevel;
    logic       woverflow;

    int n_checks = 0;
    int n_errors = 0;
    int step_id  = 0;

    typedef struct {
        int         id;
        logic [3:0] wptr;
        logic [2:0] waddr;
        logic       wen;
        logic       wfull;
        logic       wafull;
        logic [3:0] wlevel;
        logic       wovf;
    } exp_t;

    exp_t exp_q[$];

    // Binary -> Gray table for 4-bit pointers
    logic [3:0] gray_tab [16];

    fifo_wptr_afull #(.ADDRSIZE(3), .AFULL_THRESH(6)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .winc      (winc),
        .wq2_rptr  (wq2_rptr),
        .wovf_clr  (wovf_clr),
        .wptr      (wptr),
        .waddr     (waddr),
        .wen       (wen),
        .wfull     (wfull),
        .wafull    (wafull),
        .wlevel    (wlevel),
        .woverflow (woverflow)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic cmp(input int id, input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL step %0d %s: got %h expected %h", id, nm, got, exp);
        end
    endtask

    task automatic check_vec(input exp_t e);
        cmp(e.id, "wptr",      wptr,              e.wptr);
        cmp(e.id, "waddr",     {1'b0, waddr},     {1'b0, e.waddr});
        cmp(e.id, "wen",       {3'b000, wen},     {3'b000, e.wen});
        cmp(e.id, "wfull",     {3'b000, wfull},   {3'b000, e.wfull});
        cmp(e.id, "wafull",    {3'b000, wafull},  {3'b000, e.wafull});
        cmp(e.id, "wlevel",    wlevel,            e.wlevel);
        cmp(e.id, "woverflow", {3'b000, woverflow}, {3'b000, e.wovf});
    endtask

    // Monitor: compare the oldest expectation shortly after each edge.
    always @(posedge wclk) begin
        #2;
        if (exp_q.size() > 0) begin
            check_vec(exp_q.pop_front());
        end
    end

    // One clock of stimulus; expected values describe the state after the edge.
    // wen is combinational, so its expectation uses the still-held winc.
    task automatic step(input logic i_inc, input logic [3:0] i_rptr, input logic i_clr,
                        input logic [3:0] e_ptr, input logic [2:0] e_addr,
                        input logic e_full, input logic e_afull,
                        input logic [3:0] e_lvl, input logic e_ovf);
        exp_t e;
        winc     = i_inc;
        wq2_rptr = i_rptr;
        wovf_clr = i_clr;
        @(posedge wclk);
        step_id++;
        e.id     = step_id;
        e.wptr   = e_ptr;
        e.waddr  = e_addr;
        e.wen    = i_inc & ~e_full;
        e.wfull  = e_full;
        e.wafull = e_afull;
        e.wlevel = e_lvl;
        e.wovf   = e_ovf;
        exp_q.push_back(e);
        #4;
    endtask

    task automatic check_reset_zero(input int id, input logic e_wen);
        exp_t e;
        e.id = id; e.wptr = 4'h0; e.waddr = 3'd0; e.wen = e_wen;
        e.wfull = 1'b0; e.wafull = 1'b0; e.wlevel = 4'd0; e.wovf = 1'b0;
        check_vec(e);
    endtask

    initial begin
        gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                     4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        wrst_n   = 1'b1;
        winc     = 1'b0;
        wq2_rptr = 4'h0;
        wovf_clr = 1'b0;

        // Reset state, including no update on an edge while reset is held
        #1 wrst_n = 1'b0;
        #2 check_reset_zero(1000, 1'b0);
        winc = 1'b1;
        #1 check_reset_zero(1001, 1'b1);
        @(posedge wclk);
        #2 check_reset_zero(1002, 1'b1);
        winc = 1'b0;
        @(negedge wclk);
        wrst_n = 1'b1;

        // Fill: 8 writes, read pointer at 0
        step(1'b1, 4'h0, 1'b0, 4'h1, 3'd1, 1'b0, 1'b0, 4'd1, 1'b0);
        step(1'b1, 4'h0, 1'b0, 4'h3, 3'd2, 1'b0, 1'b0, 4'd2, 1'b0);
        step(1'b1, 4'h0, 1'b0, 4'h2, 3'd3, 1'b0, 1'b0, 4'd3, 1'b0);
        step(1'b1, 4'h0, 1'b0, 4'h6, 3'd4, 1'b0, 1'b0, 4'd4, 1'b0);
        step(1'b1, 4'h0, 1'b0, 4'h7, 3'd5, 1'b0, 1'b0, 4'd5, 1'b0);
        step(1'b1, 4'h0, 1'b0, 4'h5, 3'd6, 1'b0, 1'b1, 4'd6, 1'b0);
        step(1'b1, 4'h0, 1'b0, 4'h4, 3'd7, 1'b0, 1'b1, 4'd7, 1'b0);
        step(1'b1, 4'h0, 1'b0, 4'hC, 3'd0, 1'b1, 1'b1, 4'd8, 1'b0);

        // Writes while full: rejected, overflow set and sticky
        step(1'b1, 4'h0, 1'b0, 4'hC, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1);
        step(1'b1, 4'h0, 1'b0, 4'hC, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1);
        step(1'b1, 4'h0, 1'b0, 4'hC, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1);
        step(1'b0, 4'h0, 1'b1, 4'hC, 3'd0, 1'b1, 1'b1, 4'd8, 1'b0);
        step(1'b1, 4'h0, 1'b0, 4'hC, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1);
        step(1'b1, 4'h0, 1'b1, 4'hC, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1);
        step(1'b0, 4'h0, 1'b1, 4'hC, 3'd0, 1'b1, 1'b1, 4'd8, 1'b0);

        // Read advance frees a slot, then one write refills
        step(1'b0, 4'h1, 1'b0, 4'hC, 3'd0, 1'b0, 1'b1, 4'd7, 1'b0);
        step(1'b1, 4'h1, 1'b0, 4'hD, 3'd1, 1'b1, 1'b1, 4'd8, 1'b0);

        // Drain to level 4 via read advances only
        step(1'b0, 4'h3, 1'b0, 4'hD, 3'd1, 1'b0, 1'b1, 4'd7, 1'b0);
        step(1'b0, 4'h2, 1'b0, 4'hD, 3'd1, 1'b0, 1'b1, 4'd6, 1'b0);
        step(1'b0, 4'h6, 1'b0, 4'hD, 3'd1, 1'b0, 1'b0, 4'd5, 1'b0);
        step(1'b0, 4'h7, 1'b0, 4'hD, 3'd1, 1'b0, 1'b0, 4'd4, 1'b0);

        // Simultaneous write and read advance at level 4
        step(1'b1, 4'h5, 1'b0, 4'hF, 3'd2, 1'b0, 1'b0, 4'd4, 1'b0);

        // Wrap-around: 16 writes with matching read advances (wbin from 10, rbin from 6)
        for (int k = 1; k <= 16; k++) begin
            int wb;
            int rb;
            wb = (10 + k) % 16;
            rb = (6 + k) % 16;
            step(1'b1, gray_tab[rb], 1'b0, gray_tab[wb], wb[2:0], 1'b0, 1'b0, 4'd4, 1'b0);
        end

        // Reach level 5, then reset asynchronously mid-cycle
        step(1'b1, 4'h5, 1'b0, 4'hE, 3'd3, 1'b0, 1'b0, 4'd5, 1'b0);
        winc     = 1'b0;
        wq2_rptr = 4'h0;
        wrst_n   = 1'b0;
        #1 check_reset_zero(2000, 1'b0);
        @(negedge wclk);
        wrst_n = 1'b1;
        step(1'b1, 4'h0, 1'b0, 4'h1, 3'd1, 1'b0, 1'b0, 4'd1, 1'b0);
        step(1'b0, 4'h0, 1'b0, 4'h1, 3'd1, 1'b0, 1'b0, 4'd1, 1'b0);

        // Let the monitor drain outstanding expectations, bounded
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge wclk);
            #3;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit
    initial begin
        #100000;
        n_errors++;
        $display("FAIL timeout: got no finish expected finish before limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/fifo_wptr_afull.md
FIFO_WPTR_AFULL -- requirements
Module: fifo_wptr_afull

Interface
REQ-001 Parameter ADDRSIZE, default 4: the FIFO depth SHALL be 2**ADDRSIZE. Legal range is ADDRSIZE >= 2.
REQ-002 Parameter AFULL_THRESH, default 2**ADDRSIZE-2: the almost-full level SHALL be AFULL_THRESH. Legal range is 1..2**ADDRSIZE.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-004 wclk  input  1  write-domain clock, rising edge.
REQ-005 wrst_n  input  1  asynchronous active-low reset.
REQ-006 winc  input  1  write request.
REQ-007 wq2_rptr  input  ADDRSIZE+1  read pointer, Gray-coded, already synchronised into wclk.
REQ-008 wovf_clr  input  1  clear for the sticky overflow flag.
REQ-009 wptr  output  ADDRSIZE+1  registered Gray write pointer, sent to the read domain.
REQ-010 waddr  output  ADDRSIZE  RAM write address.
REQ-011 wen  output  1  RAM write enable.
REQ-012 wfull  output  1  registered full flag.
REQ-013 wafull  output  1  registered almost-full flag.
REQ-014 wlevel  output  ADDRSIZE+1  registered fill level, range 0..2**ADDRSIZE.
REQ-015 woverflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-016 Write enable: wen SHALL equal winc & ~wfull, combinationally.
REQ-017 Binary counter: an internal binary pointer wbin (ADDRSIZE+1 bits) SHALL be kept.
  - wbnext = wbin + wen, modulo 2**(ADDRSIZE+1).
  - wbin <= wbnext on every wclk edge.
REQ-018 Gray pointer: wgnext = (wbnext >> 1) ^ wbnext, and wptr <= wgnext each cycle.
  - wptr SHALL change by exactly one bit per accepted write.
  - wptr SHALL never glitch, because it is a register output.
REQ-019 Address: waddr SHALL equal wbin[ADDRSIZE-1:0].
  - The address wraps from 2**ADDRSIZE-1 to 0.
  - The pointer MSB toggles on each wrap.
REQ-020 Full flag: wfull <= (wgnext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - wfull SHALL assert on the same clock edge that accepts the final write.
REQ-021 Read-pointer conversion: wq2_rptr SHALL be converted Gray-to-binary combinationally to rbin, using an XOR prefix from the MSB down.
REQ-022 Level: wlevel <= (wbnext - rbin) modulo 2**(ADDRSIZE+1).
  - wlevel SHALL reach 2**ADDRSIZE exactly when wfull asserts.
REQ-023 Almost-full: wafull <= (wbnext - rbin) >= AFULL_THRESH, using the same arithmetic as wlevel.
  - When AFULL_THRESH = 2**ADDRSIZE, wafull SHALL equal wfull.
REQ-024 Overflow:
  - woverflow <= 1 when winc & wfull.
  - Otherwise woverflow <= 0 when wovf_clr.
  - If set and clear occur in the same cycle, set SHALL win.
REQ-025 Rejected writes: a write rejected while full SHALL NOT change wbin, wptr, waddr or wlevel.
REQ-026 Read advance while full: wfull SHALL deassert on the first edge after wq2_rptr advances, with no write needed.
REQ-027 Simultaneous write and read advance: when winc=1 and wq2_rptr advances in the same cycle, wlevel SHALL be unchanged.
REQ-028 Stale read pointer: wq2_rptr lags the read domain by two or more cycles, so wfull and wafull are pessimistic only. The block SHALL never report fewer entries than are truly present.

Reset
REQ-029 While wrst_n=0, all of the following SHALL be 0 asynchronously: wbin, wptr, wfull, wafull, wlevel, woverflow.
  - waddr=0 and wen=winc follow from these values.
REQ-030 When wrst_n is asserted mid-operation, the block SHALL discard all pointer state with no partial update.
REQ-031 State SHALL first update on the first wclk rising edge after wrst_n deasserts.
REQ-032 The reset SHALL be asynchronous on every flop in the block.

Verification (ADDRSIZE=3, depth 8, AFULL_THRESH=6, wq2_rptr held 0 unless stated)
REQ-033 Reset, then winc=1 for 8 cycles:
  - wptr goes 1,3,2,6,7,5,4,C (hex).
  - waddr goes 0..7.
  - wafull rises after the 6th write.
  - wfull=1 and wlevel=8 after the 8th write.
REQ-034 Write while full: from full, winc=1 for 3 cycles.
  - wen=0 throughout.
  - wptr stays C and wlevel stays 8.
  - woverflow=1 and stays 1.
  - Pulsing wovf_clr with winc=0 clears woverflow next cycle.
  - wovf_clr together with winc at full leaves woverflow=1.
REQ-035 Read frees space: from full, set wq2_rptr=1 (Gray).
  - Next edge: wfull=0, wlevel=7, wafull=1.
  - One write then gives wfull=1, wptr=D, wlevel=8.
REQ-036 Wrap-around: 16 writes interleaved with matching wq2_rptr advances.
  - waddr wraps 7->0.
  - wptr MSB toggles at write 8 and write 16.
  - wlevel stays constant and wfull never asserts.
REQ-037 Mid-operation reset: assert wrst_n=0 asynchronously mid-cycle at level 5.
  - All outputs read 0 immediately, without waiting for a clock.
  - After release, the first write gives wptr=1 and wlevel=1.
REQ-038 Simultaneous write and read at level 4: winc=1 with wq2_rptr advancing by one in the same cycle leaves wlevel=4 and wafull=0.
